// File: rtl/datapath.sv
// Register-file-plus-ALU execution datapath: two combinational read ports, one
// ALU, registered writeback and registered NZCV flags.
module datapath (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] read_reg_num1,
    input  logic [4:0] read_reg_num2,
    input  logic [4:0] write_reg,
    input  logic [3:0] alu_control,
    input  logic       regwrite,
    output logic       zero_flag,
    output logic       carry_flag,
    output logic       overflow_flag,
    output logic       negative_flag
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADDS = 4'b0010;
    localparam logic [3:0] OP_SUBS = 4'b0011;
    localparam logic [3:0] OP_CMP  = 4'b0100;
    localparam logic [3:0] OP_CMN  = 4'b0101;
    localparam logic [3:0] OP_TST  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_MVN  = 4'b1010;
    localparam logic [3:0] OP_BIC  = 4'b1011;
    localparam logic [3:0] OP_MOV  = 4'b1100;

    logic [31:0] regs [32];
    logic [31:0] a, b, r;
    logic [32:0] sum, diff;
    logic        is_sub, set_nzcv, set_nz, wb_en;
    logic        c_new, v_new;

    assign a    = regs[read_reg_num1];
    assign b    = regs[read_reg_num2];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        r        = 32'd0;
        is_sub   = 1'b0;
        set_nzcv = 1'b0;
        set_nz   = 1'b0;
        case (alu_control)
            OP_ADD:  r = sum[31:0];
            OP_SUB:  begin r = diff[31:0]; is_sub = 1'b1; end
            OP_ADDS: begin r = sum[31:0];  set_nzcv = 1'b1; end
            OP_SUBS: begin r = diff[31:0]; is_sub = 1'b1; set_nzcv = 1'b1; end
            OP_CMP:  begin r = diff[31:0]; is_sub = 1'b1; set_nzcv = 1'b1; end
            OP_CMN:  begin r = sum[31:0];  set_nzcv = 1'b1; end
            OP_TST:  begin r = a & b;      set_nz = 1'b1; end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_MVN:  r = ~a;
            OP_BIC:  r = a & ~b;
            OP_MOV:  r = a;
            default: r = 32'd0;
        endcase
    end

    // Subtract carry is NOT borrow, so it inverts the 33rd bit of the difference.
    always_comb begin
        if (is_sub) begin
            c_new = ~diff[32];
            v_new = (a[31] != b[31]) && (diff[31] != a[31]);
        end else begin
            c_new = sum[32];
            v_new = (a[31] == b[31]) && (sum[31] != a[31]);
        end
    end

    assign wb_en = regwrite && (alu_control != OP_CMP) &&
                   (alu_control != OP_CMN) && (alu_control != OP_TST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
        end else if (wb_en) begin
            regs[write_reg] <= r;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            negative_flag <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else if (set_nzcv || set_nz) begin
            negative_flag <= r[31];
            zero_flag     <= (r == 32'd0);
            if (set_nzcv) begin
                carry_flag    <= c_new;
                overflow_flag <= v_new;
            end
        end
    end
endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath; register contents are observed
// through the register array, flags through the ports.
module tb_datapath;
    logic       clock, reset;
    logic [4:0] read_reg_num1, read_reg_num2, write_reg;
    logic [3:0] alu_control;
    logic       regwrite;
    logic       zero_flag, carry_flag, overflow_flag, negative_flag;

    int checks = 0;
    int errors = 0;

    datapath dut (
        .clock(clock), .reset(reset),
        .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
        .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .overflow_flag(overflow_flag), .negative_flag(negative_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] nzcv();
        return {negative_flag, zero_flag, carry_flag, overflow_flag};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operation and let a single rising edge take it.
    task automatic op(input logic [3:0] ctl, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [4:0] rw, input logic we);
        alu_control = ctl; read_reg_num1 = ra; read_reg_num2 = rb;
        write_reg = rw; regwrite = we;
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b0; alu_control = 4'd0; read_reg_num1 = 5'd0;
        read_reg_num2 = 5'd0; write_reg = 5'd0; regwrite = 1'b0;
        #12;
        chk("reset_flags", 32'(nzcv()), 32'h0);
        chk("reset_r2", dut.regs[2], 32'd2);
        chk("reset_r31", dut.regs[31], 32'd31);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;

        op(4'b0000, 5'd0, 5'd1, 5'd2, 1'b1);
        chk("add_r2", dut.regs[2], 32'd1);
        chk("add_flags", 32'(nzcv()), 32'h0);

        op(4'b0011, 5'd6, 5'd7, 5'd8, 1'b1);
        chk("subs_r8", dut.regs[8], 32'hFFFF_FFFF);
        chk("subs_flags", 32'(nzcv()), 32'b1000);

        op(4'b0010, 5'd8, 5'd1, 5'd5, 1'b1);
        chk("adds_r5", dut.regs[5], 32'd0);
        chk("adds_flags", 32'(nzcv()), 32'b0110);

        op(4'b0100, 5'd20, 5'd20, 5'd21, 1'b1);
        chk("cmp_flags", 32'(nzcv()), 32'b0110);
        chk("cmp_r20", dut.regs[20], 32'd20);
        chk("cmp_r21", dut.regs[21], 32'd21);

        op(4'b0111, 5'd9, 5'd10, 5'd11, 1'b1);
        chk("and_r11", dut.regs[11], 32'd8);
        chk("and_flags", 32'(nzcv()), 32'b0110);
        op(4'b1000, 5'd12, 5'd13, 5'd14, 1'b1);
        chk("or_r14", dut.regs[14], 32'd13);
        op(4'b1001, 5'd15, 5'd16, 5'd17, 1'b1);
        chk("xor_r17", dut.regs[17], 32'd31);
        op(4'b1010, 5'd18, 5'd0, 5'd19, 1'b1);
        chk("mvn_r19", dut.regs[19], 32'hFFFF_FFED);
        op(4'b1011, 5'd15, 5'd16, 5'd22, 1'b1);
        chk("bic_r22", dut.regs[22], 32'd15);
        op(4'b1100, 5'd30, 5'd0, 5'd29, 1'b1);
        chk("mov_r29", dut.regs[29], 32'd30);
        op(4'b1101, 5'd30, 5'd31, 5'd28, 1'b1);
        chk("rsvd_r28", dut.regs[28], 32'd0);
        op(4'b0001, 5'd3, 5'd4, 5'd27, 1'b1);
        chk("sub_r27", dut.regs[27], 32'hFFFF_FFFF);
        chk("logic_flags_hold", 32'(nzcv()), 32'b0110);

        op(4'b0000, 5'd0, 5'd1, 5'd2, 1'b0);
        chk("nowe_r2", dut.regs[2], 32'd1);

        op(4'b0101, 5'd31, 5'd1, 5'd0, 1'b1);
        chk("cmn_flags", 32'(nzcv()), 32'b0000);
        chk("cmn_r0", dut.regs[0], 32'd0);

        // Build 0x80000000 in r23 (r23 = 1 doubled 31 times) to exercise V.
        op(4'b1100, 5'd1, 5'd0, 5'd23, 1'b1);
        for (int i = 0; i < 31; i++) op(4'b0000, 5'd23, 5'd23, 5'd23, 1'b1);
        chk("build_r23", dut.regs[23], 32'h8000_0000);
        op(4'b0011, 5'd0, 5'd23, 5'd24, 1'b1);
        chk("subs_v_r24", dut.regs[24], 32'h8000_0000);
        chk("subs_v_flags", 32'(nzcv()), 32'b1001);
        op(4'b0010, 5'd23, 5'd23, 5'd25, 1'b1);
        chk("adds_v_r25", dut.regs[25], 32'd0);
        chk("adds_v_flags", 32'(nzcv()), 32'b0111);
        op(4'b0110, 5'd23, 5'd23, 5'd26, 1'b1);
        chk("tst_flags", 32'(nzcv()), 32'b1011);
        chk("tst_r26", dut.regs[26], 32'd26);

        op(4'b0011, 5'd0, 5'd1, 5'd3, 1'b0);
        chk("subs_n_flags", 32'(nzcv()), 32'b1000);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_flags", 32'(nzcv()), 32'h0);
        chk("async_rst_r2", dut.regs[2], 32'd2);
        chk("async_rst_r23", dut.regs[23], 32'd23);
        @(posedge clock); #1;
        chk("rst_blocks_write", dut.regs[3], 32'd3);
        chk("rst_blocks_flags", 32'(nzcv()), 32'h0);
        @(negedge clock); reset = 1'b1;

        op(4'b0011, 5'd3, 5'd4, 5'd9, 1'b1);
        chk("resume_r9", dut.regs[9], 32'hFFFF_FFFF);
        chk("resume_flags", 32'(nzcv()), 32'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
